// File: rtl/spi_burst_arbiter.sv
// spi_burst_arbiter
//
// Shares one SPI master between NREQ device controllers. Requests are served
// round-robin, one multi-word burst at a time. The owner's chip-select hold
// stays high for the whole burst. TX and RX words move one at a time, so only
// one word is ever in flight. If the master stops returning words, a watchdog
// aborts the burst so the bus cannot hang.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   req             per-requester burst request (level, sampled only in IDLE)
//   req_words       6-bit word count per requester, slice i = [6i+5:6i]
//   req_tx_data     current TX byte per requester, advanced after tx_ack[i]
//   gnt             one-hot owner of the current burst
//   tx_ack          1-cycle pulse: owner's TX byte consumed
//   rx_valid        1-cycle pulse: rx_data holds the owner's received byte
//   rx_data         last received byte (shared by all requesters)
//   done, err       1-cycle end-of-burst pulse; err=1 means aborted by timeout
//   ss_hold         one-hot chip-select hold for the whole burst
//   spi_ready_in    master idle and able to accept a word
//   spi_valid_in    master returns one received word on spi_data_in
//   spi_en          1-cycle start pulse for one word on spi_data_out
//   spi_data_words  word count of the latched burst
//
// All outputs are registered.

module spi_burst_arbiter #(
    parameter int DATA_BITS = 8,
    parameter int NREQ      = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [6*NREQ-1:0]         req_words,
    input  logic [DATA_BITS*NREQ-1:0] req_tx_data,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           tx_ack,
    output logic [NREQ-1:0]           rx_valid,
    output logic [DATA_BITS-1:0]      rx_data,
    output logic [NREQ-1:0]           done,
    output logic                      err,
    output logic [NREQ-1:0]           ss_hold,
    input  logic                      spi_ready_in,
    input  logic                      spi_valid_in,
    input  logic [DATA_BITS-1:0]      spi_data_in,
    output logic                      spi_en,
    output logic [DATA_BITS-1:0]      spi_data_out,
    output logic [5:0]                spi_data_words
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // The watchdog counts the cycles already spent in WAIT_RX; the cycle in
    // which it holds TIMEOUT-1 is the last one we are willing to wait.
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ISSUE   = 3'd2,
        WAIT_RX = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]          owner, owner_nxt;
    logic [5:0]             words_reg, words_nxt;
    logic [5:0]             cnt, cnt_nxt;
    logic [WW-1:0]          wd, wd_nxt;
    logic                   abort, abort_nxt;

    logic                   pick_ok;
    logic [IW-1:0]          pick_idx;

    logic [NREQ-1:0]        gnt_nxt, ss_hold_nxt, tx_ack_nxt, rx_valid_nxt, done_nxt;
    logic                   err_nxt, spi_en_nxt;
    logic [DATA_BITS-1:0]   rx_data_nxt, spi_data_out_nxt;
    logic [5:0]             spi_data_words_nxt;

    // First set request bit searching upward from ptr with wrap.
    // Result MSB flags that a request was found.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   ptr);
        logic [IW:0] res;
        int          c;
        res = '0;
        // Walk from the farthest candidate back to ptr so the nearest wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % NREQ;
            if (r[c]) res = {1'b1, IW'(c)};
        end
        return res;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

    always_comb begin
        state_nxt          = state;
        rr_ptr_nxt         = rr_ptr;
        owner_nxt          = owner;
        words_nxt          = words_reg;
        cnt_nxt            = cnt;
        wd_nxt             = wd;
        abort_nxt          = abort;
        gnt_nxt            = gnt;
        ss_hold_nxt        = ss_hold;
        rx_data_nxt        = rx_data;
        spi_data_out_nxt   = spi_data_out;
        spi_data_words_nxt = spi_data_words;
        tx_ack_nxt         = '0;
        rx_valid_nxt       = '0;
        done_nxt           = '0;
        err_nxt            = 1'b0;
        spi_en_nxt         = 1'b0;

        {pick_ok, pick_idx} = rr_pick(req, rr_ptr);

        case (state)
            IDLE: begin
                if (pick_ok) begin
                    owner_nxt          = pick_idx;
                    words_nxt          = req_words[6*int'(pick_idx) +: 6];
                    spi_data_words_nxt = req_words[6*int'(pick_idx) +: 6];
                    cnt_nxt            = '0;
                    abort_nxt          = 1'b0;
                    gnt_nxt            = onehot(pick_idx);
                    ss_hold_nxt        = onehot(pick_idx);
                    state_nxt          = LOAD;
                end
            end

            LOAD: begin
                state_nxt = (words_reg == 6'd0) ? DONE : ISSUE;
            end

            ISSUE: begin
                if (spi_ready_in) begin
                    spi_en_nxt       = 1'b1;
                    spi_data_out_nxt = req_tx_data[DATA_BITS*int'(owner) +: DATA_BITS];
                    tx_ack_nxt       = onehot(owner);
                    wd_nxt           = '0;
                    state_nxt        = WAIT_RX;
                end
            end

            WAIT_RX: begin
                if (spi_valid_in) begin
                    rx_data_nxt  = spi_data_in;
                    rx_valid_nxt = onehot(owner);
                    cnt_nxt      = cnt + 6'd1;
                    state_nxt    = (cnt + 6'd1 == words_reg) ? DONE : ISSUE;
                end else if (wd == WD_LAST) begin
                    abort_nxt = 1'b1;
                    state_nxt = DONE;
                end else begin
                    wd_nxt = wd + 1'b1;
                end
            end

            DONE: begin
                done_nxt    = onehot(owner);
                err_nxt     = abort;
                gnt_nxt     = '0;
                ss_hold_nxt = '0;
                rr_ptr_nxt  = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                state_nxt   = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            words_reg      <= '0;
            cnt            <= '0;
            wd             <= '0;
            abort          <= 1'b0;
            gnt            <= '0;
            ss_hold        <= '0;
            tx_ack         <= '0;
            rx_valid       <= '0;
            rx_data        <= '0;
            done           <= '0;
            err            <= 1'b0;
            spi_en         <= 1'b0;
            spi_data_out   <= '0;
            spi_data_words <= '0;
        end else begin
            state          <= state_nxt;
            rr_ptr         <= rr_ptr_nxt;
            owner          <= owner_nxt;
            words_reg      <= words_nxt;
            cnt            <= cnt_nxt;
            wd             <= wd_nxt;
            abort          <= abort_nxt;
            gnt            <= gnt_nxt;
            ss_hold        <= ss_hold_nxt;
            tx_ack         <= tx_ack_nxt;
            rx_valid       <= rx_valid_nxt;
            rx_data        <= rx_data_nxt;
            done           <= done_nxt;
            err            <= err_nxt;
            spi_en         <= spi_en_nxt;
            spi_data_out   <= spi_data_out_nxt;
            spi_data_words <= spi_data_words_nxt;
        end
    end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Testbench for spi_burst_arbiter: requesters and an SPI master model drive the
// DUT; a reference model predicts grants, words, received bytes and done/err,
// and a monitor compares every DUT output event against the predictions.

module tb_spi_burst_arbiter;

    localparam int DB = 8;
    localparam int NR = 3;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [6*NR-1:0]   req_words;
    logic [DB*NR-1:0]  req_tx_data;
    logic [NR-1:0]     gnt, tx_ack, rx_valid, done, ss_hold;
    logic [DB-1:0]     rx_data;
    logic              err;
    logic              spi_ready_in, spi_valid_in, spi_en;
    logic [DB-1:0]     spi_data_in, spi_data_out;
    logic [5:0]        spi_data_words;

    always #5 clk = ~clk;

    spi_burst_arbiter #(.DATA_BITS(DB), .NREQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_words(req_words),
        .req_tx_data(req_tx_data), .gnt(gnt), .tx_ack(tx_ack),
        .rx_valid(rx_valid), .rx_data(rx_data), .done(done), .err(err),
        .ss_hold(ss_hold), .spi_ready_in(spi_ready_in),
        .spi_valid_in(spi_valid_in), .spi_data_in(spi_data_in),
        .spi_en(spi_en), .spi_data_out(spi_data_out),
        .spi_data_words(spi_data_words)
    );

    typedef struct { int o; int w; }              gnt_t;
    typedef struct { logic [7:0] d; bit drop; }   spi_t;
    typedef struct { int o; logic [7:0] d; }      rx_t;
    typedef struct { int o; bit e; }              done_t;

    gnt_t  exp_gnt[$];
    spi_t  exp_spi[$];
    rx_t   exp_rx[$];
    done_t exp_done[$];
    spi_t  mplan[$];

    int checks = 0;
    int errors = 0;

    // Burst configuration for the next scenario.
    int         words_a[NR];
    int         abort_a[NR];
    logic [7:0] tx_a[NR][8];
    logic [7:0] rx_a[NR][8];
    int         rr_model = 0;

    bit  rand_mode = 1'b0;
    int  ready_low = 0;

    int   cyc = 0;
    logic rst_s = 1'b1;
    logic ready_s = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_s   <= rst;
        ready_s <= spi_ready_in;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: all requesters in mask are raised together while the
    // arbiter is idle and each holds until granted, so service order is the
    // rotation of mask starting at the round-robin pointer.
    task automatic plan_scn(input logic [NR-1:0] mask);
        int start, o;
        bit e;
        start = rr_model;
        for (int k = 0; k < NR; k++) begin
            o = (start + k) % NR;
            if (mask[o]) begin
                exp_gnt.push_back('{o, words_a[o]});
                e = 1'b0;
                for (int j = 0; j < words_a[o]; j++) begin
                    if (j == abort_a[o]) begin
                        exp_spi.push_back('{tx_a[o][j], 1'b1});
                        mplan.push_back('{8'h00, 1'b1});
                        e = 1'b1;
                        break;
                    end
                    exp_spi.push_back('{tx_a[o][j], 1'b0});
                    exp_rx.push_back('{o, rx_a[o][j]});
                    mplan.push_back('{rx_a[o][j], 1'b0});
                end
                exp_done.push_back('{o, e});
                rr_model = (o + 1) % NR;
            end
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < NR; i++) begin
            words_a[i] = 0;
            abort_a[i] = -1;
            for (int j = 0; j < 8; j++) begin
                tx_a[i][j] = 8'($urandom);
                rx_a[i][j] = 8'($urandom);
            end
        end
    endtask

    task automatic run_scn(input logic [NR-1:0] mask);
        int txi[NR];
        int remaining, budget;
        plan_scn(mask);
        remaining = $countones(mask);
        for (int i = 0; i < NR; i++) begin
            txi[i] = 0;
            req_words[6*i +: 6]    = 6'(words_a[i]);
            req_tx_data[DB*i +: DB] = tx_a[i][0];
        end
        req = mask;
        budget = 2000;
        while (remaining > 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            for (int i = 0; i < NR; i++) begin
                if (gnt[i]) req[i] = 1'b0;
                if (tx_ack[i] && txi[i] < 7) begin
                    txi[i]++;
                    req_tx_data[DB*i +: DB] = tx_a[i][txi[i]];
                end
                if (done[i]) remaining--;
            end
        end
        chk("scenario_complete", longint'(remaining), 0);
        req = '0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    // Master model: accepts words, answers from the plan after a random delay,
    // or goes silent for a planned dropped word.
    initial begin : master
        bit         busy, hang;
        int         dly;
        logic [7:0] rdata;
        spi_t       p;
        busy = 1'b0; hang = 1'b0; dly = 0; rdata = '0;
        spi_ready_in = 1'b0; spi_valid_in = 1'b0; spi_data_in = '0;
        forever begin
            @(posedge clk); #1;
            spi_valid_in = 1'b0;
            if (ready_low > 0) begin
                spi_ready_in = 1'b0;
                ready_low--;
            end else begin
                spi_ready_in = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (rst_s) begin
                busy = 1'b0;
                hang = 1'b0;
            end else begin
                if (done != '0) hang = 1'b0;
                if (spi_en) begin
                    if (mplan.size() == 0) begin
                        hang = 1'b1;
                    end else begin
                        p = mplan.pop_front();
                        if (p.drop) begin
                            hang = 1'b1;
                        end else begin
                            busy  = 1'b1;
                            dly   = $urandom_range(0, 3);
                            rdata = p.d;
                        end
                    end
                end
                if (busy) begin
                    if (dly == 0) begin
                        spi_valid_in = 1'b1;
                        spi_data_in  = rdata;
                        busy         = 1'b0;
                    end else begin
                        dly--;
                    end
                end else if (rand_mode && !hang && !spi_en && $urandom_range(0, 9) == 0) begin
                    // Stray word outside WAIT_RX; the arbiter must ignore it.
                    spi_valid_in = 1'b1;
                    spi_data_in  = 8'($urandom);
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        logic [NR-1:0] gnt_prev;
        bit            inflight;
        int            en_cyc, gnt_cyc, cur_w;
        gnt_t          g;
        spi_t          s;
        rx_t           r;
        done_t         d;
        gnt_prev = '0; inflight = 1'b0; en_cyc = 0; gnt_cyc = 0; cur_w = 0;
        forever begin
            @(negedge clk);
            if (rst_s) begin
                chk("reset_outputs_zero",
                    longint'({gnt, ss_hold, tx_ack, rx_valid, done, err, spi_en,
                              rx_data, spi_data_out, spi_data_words}), 0);
                inflight = 1'b0;
                gnt_prev = '0;
            end else begin
                chk("one_hot_and_ss_eq_gnt",
                    longint'($onehot0(gnt) && $onehot0(tx_ack) && $onehot0(rx_valid)
                             && $onehot0(done) && (ss_hold == gnt)), 1);
                chk("err_only_with_done", longint'(err && done == '0), 0);
                chk("tx_ack_only_with_en", longint'(tx_ack != '0 && !spi_en), 0);

                if (gnt != '0 && gnt_prev == '0) begin
                    if (exp_gnt.size() == 0) begin
                        chk("unexpected_grant", longint'(gnt), 0);
                    end else begin
                        g = exp_gnt.pop_front();
                        chk("grant_owner", longint'(gnt), longint'(NR'(1) << g.o));
                        chk("burst_words", longint'(spi_data_words), longint'(g.w));
                        gnt_cyc = cyc;
                        cur_w   = g.w;
                    end
                end
                if (gnt != '0 && gnt_prev != '0)
                    chk("grant_stable", longint'(gnt), longint'(gnt_prev));

                if (spi_en) begin
                    chk("ready_before_en", longint'(ready_s), 1);
                    chk("single_in_flight", longint'(inflight), 0);
                    chk("tx_ack_is_owner", longint'(tx_ack), longint'(gnt));
                    if (exp_spi.size() == 0) begin
                        chk("unexpected_spi_en", longint'(spi_data_out), 0);
                    end else begin
                        s = exp_spi.pop_front();
                        chk("spi_data_out", longint'(spi_data_out), longint'(s.d));
                    end
                    inflight = 1'b1;
                    en_cyc   = cyc;
                end

                if (rx_valid != '0) begin
                    chk("rx_has_word_in_flight", longint'(inflight), 1);
                    if (exp_rx.size() == 0) begin
                        chk("unexpected_rx_valid", longint'(rx_valid), 0);
                    end else begin
                        r = exp_rx.pop_front();
                        chk("rx_owner", longint'(rx_valid), longint'(NR'(1) << r.o));
                        chk("rx_data", longint'(rx_data), longint'(r.d));
                    end
                    inflight = 1'b0;
                end

                if (done != '0) begin
                    chk("gnt_low_at_done", longint'(gnt), 0);
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", longint'(done), 0);
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_owner", longint'(done), longint'(NR'(1) << d.o));
                        chk("done_err", longint'(err), longint'(d.e));
                        if (d.e)
                            chk("timeout_latency", longint'(cyc - en_cyc), longint'(TO + 1));
                        if (cur_w == 0)
                            chk("zero_len_latency", longint'(cyc - gnt_cyc), 2);
                    end
                    inflight = 1'b0;
                end
                gnt_prev = gnt;
            end
        end
    end

    logic [NR-1:0] rmask;

    initial begin : stimulus
        int acks, budget;
        rst = 1'b1; req = '0; req_words = '0; req_tx_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single 2-word burst with known bytes.
        clear_cfg();
        words_a[0] = 2;
        tx_a[0][0] = 8'hD0; tx_a[0][1] = 8'h00;
        rx_a[0][0] = 8'hFF; rx_a[0][1] = 8'h58;
        run_scn(3'b001);

        // Zero-length burst.
        clear_cfg();
        run_scn(3'b010);

        // Timeout on the first word, then a normal burst.
        clear_cfg();
        words_a[0] = 2; abort_a[0] = 0;
        run_scn(3'b001);
        clear_cfg();
        words_a[0] = 1;
        run_scn(3'b001);

        // Backpressure: master not ready for a while.
        clear_cfg();
        words_a[2] = 1;
        ready_low = 12;
        run_scn(3'b100);

        // Simultaneous requests, one word each.
        for (int n = 0; n < 3; n++) begin
            clear_cfg();
            words_a[0] = 1; words_a[1] = 1;
            run_scn(3'b011);
        end

        // Randomized traffic.
        rand_mode = 1'b1;
        for (int s = 0; s < 40; s++) begin
            clear_cfg();
            rmask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                words_a[i] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 5);
                if (words_a[i] > 0 && $urandom_range(0, 7) == 0)
                    abort_a[i] = $urandom_range(0, words_a[i] - 1);
            end
            run_scn(rmask);
        end
        rand_mode = 1'b0;

        // Leave the pointer at 2, then reset in the middle of a 3-word burst.
        clear_cfg();
        words_a[1] = 1;
        run_scn(3'b010);

        clear_cfg();
        words_a[0] = 3;
        tx_a[0][0] = 8'hA1; tx_a[0][1] = 8'hB2; tx_a[0][2] = 8'hC3;
        rx_a[0][0] = 8'h5A; rx_a[0][1] = 8'h6B; rx_a[0][2] = 8'h7C;
        plan_scn(3'b001);
        req_words[5:0] = 6'd3;
        req_tx_data[DB-1:0] = tx_a[0][0];
        req = 3'b001;
        acks = 0; budget = 500;
        while (acks < 2 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            if (gnt[0]) req[0] = 1'b0;
            if (tx_ack[0]) begin
                acks++;
                req_tx_data[DB-1:0] = tx_a[0][acks];
            end
        end
        chk("reset_test_in_wait_rx", longint'(acks), 2);
        req = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_gnt.delete(); exp_spi.delete(); exp_rx.delete();
        exp_done.delete(); mplan.delete();
        rr_model = 0;
        repeat (2) @(posedge clk);
        #1;

        // Fresh requests after reset: pointer restarts at 0, so 1 wins first.
        clear_cfg();
        words_a[1] = 1; words_a[2] = 2;
        run_scn(3'b110);

        repeat (5) @(posedge clk);
        #1;
        chk("queues_drained",
            longint'(exp_gnt.size() + exp_spi.size() + exp_rx.size() + exp_done.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : global_guard
        #900000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/spi_burst_arbiter.md
Name: spi_burst_arbiter

Overview:
- Shares the single SPI master between NREQ device controllers, for example the BMP280 controller and a second sensor controller.
- Arbitrates round-robin and grants one multi-word burst at a time.
- Holds the owner's chip-select for the whole burst and forwards TX and RX bytes one word at a time.
- Aborts a burst if the master stops returning words, so the bus cannot hang.

Parameters:
- DATA_BITS, 8, SPI word width.
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 1023, maximum clk cycles to wait in WAIT_RX for a returned word before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester burst request; level, sampled only in IDLE.
- req_words  in  6*NREQ  word count per requester (slice i = bits 6i+5:6i); held stable while req[i] is high.
- req_tx_data  in  DATA_BITS*NREQ  next TX byte per requester; advances after each tx_ack[i].
- gnt  out  NREQ  one-hot; owner of the current burst.
- tx_ack  out  NREQ  1-cycle pulse: the owner's current TX byte has been consumed.
- rx_valid  out  NREQ  1-cycle pulse: rx_data holds the owner's received byte.
- rx_data  out  DATA_BITS  last received byte, shared by all requesters.
- done  out  NREQ  1-cycle pulse at end of the owner's burst.
- err  out  1  qualifies done: 1 = burst aborted by timeout.
- ss_hold  out  NREQ  one-hot chip-select hold, high for the whole burst.
- spi_ready_in  in  1  SPI master idle and able to accept a word.
- spi_valid_in  in  1  SPI master returns one received word.
- spi_data_in  in  DATA_BITS  received word from the SPI master.
- spi_en  out  1  1-cycle start pulse for one SPI word.
- spi_data_out  out  DATA_BITS  TX word to the SPI master.
- spi_data_words  out  6  word count of the latched burst.

Behaviour:
- Outputs: all outputs are registered.
- Reset values: state=IDLE, rr_ptr=0, all outputs 0.
- Reset mid-burst: all outputs return to reset values at the next edge; no done pulse is issued.
- States: IDLE, LOAD, ISSUE, WAIT_RX, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit searching from rr_ptr upward with wrap.
  - Latch owner and req_words[owner] into words_reg; clear cnt.
  - Next cycle: gnt[owner]=1, ss_hold[owner]=1, spi_data_words=words_reg; go to LOAD.
- LOAD:
  - If words_reg==0, go to DONE with err=0 and no SPI traffic.
  - Otherwise go to ISSUE.
- ISSUE:
  - Wait for spi_ready_in=1.
  - Then next cycle: spi_en=1, spi_data_out=req_tx_data[owner], tx_ack[owner]=1, all for exactly one cycle.
  - Clear watchdog; go to WAIT_RX.
- WAIT_RX:
  - On spi_valid_in=1, next cycle: rx_data=spi_data_in, rx_valid[owner]=1 for one cycle, cnt=cnt+1.
  - If cnt+1==words_reg go to DONE, else go to ISSUE.
  - spi_valid_in seen in any other state is ignored.
  - Watchdog increments each cycle in WAIT_RX; on reaching TIMEOUT go to DONE with err=1.
- DONE (one cycle):
  - Next cycle: done[owner]=1 and err valid, both for one cycle; gnt=0 and ss_hold=0.
  - rr_ptr = owner+1 (wrap to 0 at NREQ); return to IDLE.
  - IDLE always lasts at least one cycle, giving an SS-high guard gap between bursts.
- Requester obligations:
  - req[i] dropped mid-burst is ignored; the burst completes.
  - A requester must not re-raise req until done has been seen.
  - If req stays high, it re-arbitrates at the next IDLE.
- Fairness: with all requesters permanently requesting, grants rotate 0,1,...,NREQ-1,0.
- Overlap rules:
  - spi_en never overlaps a pending WAIT_RX; only one word is in flight.
  - gnt, ss_hold, tx_ack, rx_valid and done never have more than one bit set.
- Widths: cnt and words_reg are 6 bits, max 63 words; watchdog is clog2(TIMEOUT+1) bits.

Test Plan:
- Single burst: req[0]=1, req_words=2, TX bytes 0xD0 then 0x00, master returns 0xFF, 0x58 -> two spi_en pulses with spi_data_out 0xD0 then 0x00; rx_valid[0] with 0xFF, 0x58; done[0]=1, err=0; ss_hold[0] high from LOAD through DONE.
- Simultaneous requests: req=2'b11 every cycle, words=1 each -> grant order 0,1,0,1; ss_hold low for at least 1 cycle between bursts; one-hot checks pass.
- Zero-length burst: req[1]=1, req_words[1]=0 -> no spi_en; done[1] pulses 3 cycles after the req sample; err=0.
- Timeout: TIMEOUT=15, spi_valid_in held 0 after spi_en -> done[0] with err=1 exactly 16 cycles after entering WAIT_RX; ss_hold drops; next request serviced normally.
- Backpressure: spi_ready_in low for 10 cycles in ISSUE -> no spi_en and no tx_ack until ready rises, then exactly one of each.
- Reset mid-burst: assert rst in WAIT_RX of a 3-word burst -> next edge: all outputs 0, no done pulse, rr_ptr=0; fresh req[1] is then granted.
